// File: rtl/cav_relock.sv
// Cavity lock-acquisition controller: sweeps an offset with the PID off, hands over to
// the PID when transmission appears, qualifies the lock, and counts lock-loss events.
module cav_relock #(
   parameter int W  = 25,
   parameter int CW = 24,
   parameter int RW = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                hld_req,
   input  logic signed [W-1:0] trans,
   input  logic signed [W-1:0] th_lock,
   input  logic signed [W-1:0] th_unlock,
   input  logic signed [W-1:0] s_pid,
   input  logic signed [W-1:0] LL,
   input  logic signed [W-1:0] UL,
   input  logic signed [W-1:0] sweep_lo,
   input  logic signed [W-1:0] sweep_hi,
   input  logic signed [W-1:0] sweep_step,
   input  logic [CW-1:0]       n_settle,
   input  logic [CW-1:0]       n_rail,
   output logic                pid_on,
   output logic                pid_hld,
   output logic signed [W-1:0] sweep,
   output logic                locked,
   output logic [1:0]          state,
   output logic [RW-1:0]       relock_cnt
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SWEEP  = 2'd1,
      CATCH  = 2'd2,
      LOCKED = 2'd3
   } state_t;

   localparam logic [CW-1:0] C_ONE = CW'(1);
   localparam logic [RW-1:0] R_ONE = RW'(1);

   state_t              state_q, state_d;
   logic signed [W-1:0] sweep_q, sweep_d;
   logic                dn_q, dn_d;
   logic [CW-1:0]       settle_q, settle_d;
   logic [CW-1:0]       rail_q, rail_d;
   logic [RW-1:0]       relock_q, relock_d;
   logic                pid_on_q, pid_on_d;
   logic                pid_hld_q, pid_hld_d;
   logic                locked_q, locked_d;
   logic [CW-1:0]       settle_last;
   logic                railed, rail_hit;
   logic [W:0]          adv;

   // Returns {direction_down, next_offset}; the W+1 bit sum is clamped to the range so it never wraps.
   function automatic logic [W:0] sweep_adv(input logic signed [W-1:0] cur, lo, hi, step,
                                            input logic dn);
      logic signed [W:0] cur_x, lo_x, hi_x, step_x, nxt;
      cur_x  = {cur[W-1], cur};
      lo_x   = {lo[W-1], lo};
      hi_x   = {hi[W-1], hi};
      step_x = {step[W-1], step};
      if (lo_x >= hi_x) return {1'b0, lo};
      if (!dn) begin
         nxt = cur_x + step_x;
         if (nxt >= hi_x) return {1'b1, hi};
      end else begin
         nxt = cur_x - step_x;
         if (nxt <= lo_x) return {1'b0, lo};
      end
      return {dn, nxt[W-1:0]};
   endfunction

   function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v);
      return (&v) ? v : v + R_ONE;
   endfunction

   always_comb begin
      railed      = (s_pid >= UL) || (s_pid <= LL);
      settle_last = (n_settle == '0) ? '0 : n_settle - C_ONE;
      rail_hit    = (n_rail != '0) && railed && (rail_q == n_rail - C_ONE);
   end

   always_comb begin
      state_d  = state_q;
      sweep_d  = sweep_q;
      dn_d     = dn_q;
      settle_d = settle_q;
      rail_d   = rail_q;
      relock_d = relock_q;
      adv      = '0;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = SWEEP;
               sweep_d = sweep_lo;
               dn_d    = 1'b0;
            end
            SWEEP: begin
               if (trans >= th_lock) begin
                  state_d  = CATCH;
                  settle_d = '0;
               end else begin
                  adv     = sweep_adv(sweep_q, sweep_lo, sweep_hi, sweep_step, dn_q);
                  sweep_d = adv[W-1:0];
                  dn_d    = adv[W];
               end
            end
            CATCH: begin
               if (trans < th_unlock) begin
                  state_d = SWEEP;
               end else if (settle_q == settle_last) begin
                  state_d = LOCKED;
                  rail_d  = '0;
               end else begin
                  settle_d = settle_q + C_ONE;
               end
            end
            LOCKED: begin
               // A user hold freezes loss detection and the rail counter.
               if (!hld_req) begin
                  rail_d = railed ? rail_q + C_ONE : '0;
                  if ((trans < th_unlock) || rail_hit) begin
                     state_d  = SWEEP;
                     relock_d = sat_inc(relock_q);
                  end
               end
            end
         endcase
      end
      pid_on_d  = (state_d == CATCH) || (state_d == LOCKED);
      locked_d  = (state_d == LOCKED);
      pid_hld_d = (state_q == LOCKED) && (state_d == LOCKED) && hld_req;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sweep_q   <= '0;
         dn_q      <= 1'b0;
         settle_q  <= '0;
         rail_q    <= '0;
         relock_q  <= '0;
         pid_on_q  <= 1'b0;
         pid_hld_q <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sweep_q   <= sweep_d;
         dn_q      <= dn_d;
         settle_q  <= settle_d;
         rail_q    <= rail_d;
         relock_q  <= relock_d;
         pid_on_q  <= pid_on_d;
         pid_hld_q <= pid_hld_d;
         locked_q  <= locked_d;
      end
   end

   assign pid_on     = pid_on_q;
   assign pid_hld    = pid_hld_q;
   assign sweep      = sweep_q;
   assign locked     = locked_q;
   assign state      = state_q;
   assign relock_cnt = relock_q;
endmodule

// File: tb/tb_cav_relock.sv
// Directed bench for cav_relock; a second, narrow-counter instance exercises relock saturation.
module tb_cav_relock;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, en, hld_req, en_s;
   logic signed [24:0] trans, th_lock, th_unlock, s_pid, LL, UL;
   logic signed [24:0] sweep_lo, sweep_hi, sweep_step, trans_s, s_pid_s;
   logic [23:0] n_settle, n_rail;
   logic pid_on, pid_hld, locked;
   logic signed [24:0] sweep;
   logic [1:0] state;
   logic [15:0] relock_cnt;
   logic pid_on_s, pid_hld_s, locked_s;
   logic signed [24:0] sweep_s;
   logic [1:0] state_s;
   logic [3:0] relock_s;

   int tests = 0;
   int failed = 0;

   cav_relock dut (
      .clk(clk), .rst(rst), .en(en), .hld_req(hld_req), .trans(trans),
      .th_lock(th_lock), .th_unlock(th_unlock), .s_pid(s_pid), .LL(LL), .UL(UL),
      .sweep_lo(sweep_lo), .sweep_hi(sweep_hi), .sweep_step(sweep_step),
      .n_settle(n_settle), .n_rail(n_rail), .pid_on(pid_on), .pid_hld(pid_hld),
      .sweep(sweep), .locked(locked), .state(state), .relock_cnt(relock_cnt)
   );

   cav_relock #(.W(25), .CW(24), .RW(4)) u_sat (
      .clk(clk), .rst(rst), .en(en_s), .hld_req(hld_req), .trans(trans_s),
      .th_lock(th_lock), .th_unlock(th_unlock), .s_pid(s_pid_s), .LL(LL), .UL(UL),
      .sweep_lo(sweep_lo), .sweep_hi(sweep_hi), .sweep_step(sweep_step),
      .n_settle(n_settle), .n_rail(n_rail), .pid_on(pid_on_s), .pid_hld(pid_hld_s),
      .sweep(sweep_s), .locked(locked_s), .state(state_s), .relock_cnt(relock_s)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      tests++; if (state !== 2'd0) begin failed++; $display("FAIL reset_state: got %0d expected 0", state); end
      tests++; if (pid_on !== 1'b0 || pid_hld !== 1'b0 || locked !== 1'b0) begin failed++;
         $display("FAIL reset_flags: got on=%b hld=%b locked=%b expected 0 0 0", pid_on, pid_hld, locked); end
      tests++; if (sweep !== 25'sd0) begin failed++; $display("FAIL reset_sweep: got %0d expected 0", sweep); end
      tests++; if (relock_cnt !== 16'd0) begin failed++; $display("FAIL reset_relock: got %0d expected 0", relock_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_sweep();
      int exp_sw[16] = '{-100, -70, -40, -10, 20, 50, 80, 100, 70, 40, 10, -20, -50, -80, -100, -70};
      en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         tests++; if (int'(sweep) !== exp_sw[i] || state !== 2'd1 || pid_on !== 1'b0) begin failed++;
            $display("FAIL sweep_seq[%0d]: got sweep=%0d state=%0d pid_on=%b expected %0d 1 0",
                     i, int'(sweep), state, pid_on, exp_sw[i]); end
      end
   endtask

   task automatic test_catch();
      trans = 25'sd500;
      tick();
      tests++; if (state !== 2'd2 || sweep !== -25'sd70 || pid_on !== 1'b1) begin failed++;
         $display("FAIL catch_enter: got state=%0d sweep=%0d on=%b expected 2 -70 1", state, sweep, pid_on); end
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (state !== 2'd2 || locked !== 1'b0) begin failed++;
            $display("FAIL catch_settle[%0d]: got state=%0d locked=%b expected 2 0", i, state, locked); end
      end
      tick();
      tests++; if (state !== 2'd3 || locked !== 1'b1 || sweep !== -25'sd70) begin failed++;
         $display("FAIL catch_locked: got state=%0d locked=%b sweep=%0d expected 3 1 -70", state, locked, sweep); end
   endtask

   task automatic test_rail_loss();
      n_rail = 24'd3;
      s_pid  = 25'sd1000;
      tick();
      tick();
      tests++; if (state !== 2'd3) begin failed++; $display("FAIL rail_two_samples: got state %0d expected 3", state); end
      tick();
      tests++; if (state !== 2'd1 || relock_cnt !== 16'd1 || pid_on !== 1'b0) begin failed++;
         $display("FAIL rail_loss: got state=%0d relock=%0d on=%b expected 1 1 0", state, relock_cnt, pid_on); end
      s_pid = 25'sd0;
      trans = 25'sd0;
      tick();
      tests++; if (sweep !== -25'sd40) begin failed++; $display("FAIL rail_resume: got sweep %0d expected -40", sweep); end
   endtask

   task automatic test_catch_drop();
      trans = 25'sd500;
      tick();
      tests++; if (state !== 2'd2) begin failed++; $display("FAIL drop_enter: got state %0d expected 2", state); end
      tick();
      trans = 25'sd200;
      tick();
      tests++; if (state !== 2'd1 || sweep !== -25'sd40 || relock_cnt !== 16'd1) begin failed++;
         $display("FAIL drop_back: got state=%0d sweep=%0d relock=%0d expected 1 -40 1", state, sweep, relock_cnt); end
      trans = 25'sd0;
      tick();
      tests++; if (sweep !== -25'sd10) begin failed++; $display("FAIL drop_direction: got sweep %0d expected -10", sweep); end
   endtask

   task automatic test_hold();
      trans    = 25'sd500;
      n_settle = 24'd0;
      tick();
      tests++; if (state !== 2'd2) begin failed++; $display("FAIL settle0_catch: got state %0d expected 2", state); end
      tick();
      tests++; if (state !== 2'd3) begin failed++; $display("FAIL settle0_lock: got state %0d expected 3", state); end
      hld_req = 1'b1;
      s_pid   = 25'sd1000;
      tick();
      tests++; if (pid_hld !== 1'b1 || state !== 2'd3) begin failed++;
         $display("FAIL hold_on: got hld=%b state=%0d expected 1 3", pid_hld, state); end
      trans = 25'sd0;
      for (int i = 0; i < 5; i++) tick();
      tests++; if (pid_hld !== 1'b1 || state !== 2'd3 || relock_cnt !== 16'd1) begin failed++;
         $display("FAIL hold_keep: got hld=%b state=%0d relock=%0d expected 1 3 1", pid_hld, state, relock_cnt); end
      trans   = 25'sd500;
      hld_req = 1'b0;
      s_pid   = 25'sd0;
      tick();
      tests++; if (pid_hld !== 1'b0 || state !== 2'd3) begin failed++;
         $display("FAIL hold_off: got hld=%b state=%0d expected 0 3", pid_hld, state); end
   endtask

   task automatic test_rail_disabled();
      n_rail = 24'd0;
      s_pid  = -25'sd1000;
      for (int i = 0; i < 10; i++) tick();
      tests++; if (state !== 2'd3 || relock_cnt !== 16'd1) begin failed++;
         $display("FAIL rail_disabled: got state=%0d relock=%0d expected 3 1", state, relock_cnt); end
   endtask

   task automatic test_simultaneous();
      s_pid = 25'sd0;
      tick();
      n_rail = 24'd1;
      s_pid  = 25'sd1000;
      trans  = 25'sd0;
      tick();
      tests++; if (state !== 2'd1 || relock_cnt !== 16'd2) begin failed++;
         $display("FAIL both_loss: got state=%0d relock=%0d expected 1 2", state, relock_cnt); end
   endtask

   task automatic test_en_low();
      trans    = 25'sd500;
      s_pid    = 25'sd0;
      n_settle = 24'd1;
      tick();
      tick();
      tests++; if (state !== 2'd3) begin failed++; $display("FAIL enlow_locked: got state %0d expected 3", state); end
      en = 1'b0;
      tick();
      tests++; if (state !== 2'd0 || pid_on !== 1'b0 || locked !== 1'b0 || sweep !== -25'sd10) begin failed++;
         $display("FAIL enlow_idle: got state=%0d on=%b locked=%b sweep=%0d expected 0 0 0 -10",
                  state, pid_on, locked, sweep); end
      en    = 1'b1;
      trans = 25'sd0;
      tick();
      tests++; if (state !== 2'd1 || sweep !== -25'sd100) begin failed++;
         $display("FAIL enlow_restart: got state=%0d sweep=%0d expected 1 -100", state, sweep); end
   endtask

   task automatic test_th_inverted();
      th_lock = 25'sd100;
      trans   = 25'sd200;
      tick();
      tests++; if (state !== 2'd2) begin failed++; $display("FAIL inv_catch: got state %0d expected 2", state); end
      tick();
      tests++; if (state !== 2'd1 || sweep !== -25'sd100) begin failed++;
         $display("FAIL inv_back: got state=%0d sweep=%0d expected 1 -100", state, sweep); end
      tick();
      tests++; if (state !== 2'd2 || relock_cnt !== 16'd2) begin failed++;
         $display("FAIL inv_again: got state=%0d relock=%0d expected 2 2", state, relock_cnt); end
   endtask

   task automatic test_rst_mid_catch();
      rst = 1'b1;
      tick();
      tests++; if (state !== 2'd0 || sweep !== 25'sd0 || relock_cnt !== 16'd0 || pid_on !== 1'b0 || locked !== 1'b0)
         begin failed++;
         $display("FAIL rst_catch: got state=%0d sweep=%0d relock=%0d on=%b locked=%b expected 0 0 0 0 0",
                  state, sweep, relock_cnt, pid_on, locked); end
      rst     = 1'b0;
      en      = 1'b0;
      th_lock = 25'sd500;
      trans   = 25'sd0;
   endtask

   task automatic test_saturation();
      n_settle = 24'd1;
      n_rail   = 24'd1;
      en_s     = 1'b1;
      trans_s  = 25'sd500;
      s_pid_s  = 25'sd1000;
      tick();
      for (int i = 0; i < 14 * 3; i++) tick();
      tests++; if (relock_s !== 4'd14 || state_s !== 2'd1) begin failed++;
         $display("FAIL sat_count14: got relock=%0d state=%0d expected 14 1", relock_s, state_s); end
      for (int i = 0; i < 3; i++) tick();
      tests++; if (relock_s !== 4'd15) begin failed++; $display("FAIL sat_reach: got %0d expected 15", relock_s); end
      for (int i = 0; i < 5 * 3; i++) tick();
      tests++; if (relock_s !== 4'd15 || state_s !== 2'd1) begin failed++;
         $display("FAIL sat_hold: got relock=%0d state=%0d expected 15 1", relock_s, state_s); end
   endtask

   initial begin
      rst        = 1'b1;
      en         = 1'b0;
      en_s       = 1'b0;
      hld_req    = 1'b0;
      trans      = 25'sd0;
      trans_s    = 25'sd0;
      s_pid      = 25'sd0;
      s_pid_s    = 25'sd0;
      th_lock    = 25'sd500;
      th_unlock  = 25'sd300;
      LL         = -25'sd1000;
      UL         = 25'sd1000;
      sweep_lo   = -25'sd100;
      sweep_hi   = 25'sd100;
      sweep_step = 25'sd30;
      n_settle   = 24'd4;
      n_rail     = 24'd0;
      test_reset();
      test_sweep();
      test_catch();
      test_rail_loss();
      test_catch_drop();
      test_hold();
      test_rail_disabled();
      test_simultaneous();
      test_en_low();
      test_th_inverted();
      test_rst_mid_catch();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
